// File: rtl/or_event_aggregator.sv
// rtl/or_event_aggregator.sv - N-channel masked OR with sticky flags, clear handshake and pulse stretcher
// Optional OR_EVENT_EDGE_EN: flags/stretch trigger on rising edges instead of levels.
module or_event_aggregator #(
    parameter int N       = 3,
    parameter int STRETCH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_in,
    input  logic [N-1:0] i_mask,
    input  logic         i_clr,
    input  logic [N-1:0] i_clr_sel,
    output logic         o_y,
    output logic [N-1:0] o_flags,
    output logic         o_y_sticky,
    output logic         o_y_stretch,
    output logic         o_clr_ack
);
    localparam int CW = $clog2(STRETCH + 1);

    logic [N-1:0]  w_qual;
    logic [N-1:0]  w_ev;
    logic          w_any_ev;
    logic [CW-1:0] w_cnt_nxt;

    logic          r_y;
    logic [N-1:0]  r_flags;
    logic          r_clr_ack;
    logic [CW-1:0] r_cnt;
    logic          r_y_stretch;

    assign w_qual = i_in & ~i_mask;

`ifdef OR_EVENT_EDGE_EN
    logic [N-1:0] r_prev;

    // History tracks the raw line so unmasking a held line does not fake an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= i_in;
        end
    end

    assign w_ev = w_qual & ~r_prev;
`else
    assign w_ev = w_qual;
`endif

    assign w_any_ev = |w_ev;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_any_ev) begin
            w_cnt_nxt = CW'(STRETCH);
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_y         <= 1'b0;
            r_flags     <= '0;
            r_clr_ack   <= 1'b0;
            r_cnt       <= '0;
            r_y_stretch <= 1'b0;
        end else begin
            r_y         <= |w_qual;
            // Set has priority over a same-cycle clear.
            r_flags     <= w_ev | (r_flags & ~({N{i_clr}} & i_clr_sel));
            r_clr_ack   <= i_clr;
            r_cnt       <= w_cnt_nxt;
            r_y_stretch <= (w_cnt_nxt != '0);
        end
    end

    assign o_y         = r_y;
    assign o_flags     = r_flags;
    assign o_y_sticky  = |r_flags;
    assign o_y_stretch = r_y_stretch;
    assign o_clr_ack   = r_clr_ack;
endmodule

// File: tb/tb_or_event_aggregator.sv
// tb/tb_or_event_aggregator.sv - table/scoreboard bench for or_event_aggregator (N=3, STRETCH=4)
module tb_or_event_aggregator;
`ifdef OR_EVENT_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] in_v = '0;
    logic [2:0] mask_v = '0;
    logic       clr = 1'b0;
    logic [2:0] clr_sel = '0;
    logic       y;
    logic [2:0] flags;
    logic       y_sticky;
    logic       y_stretch;
    logic       clr_ack;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [2:0] in_v;
        logic [2:0] mask_v;
        logic       clr;
        logic [2:0] sel;
        logic       y;
        logic [2:0] flags;
        logic       st;
        logic       ack;
    } vec_t;

    typedef struct {
        logic       y;
        logic [2:0] flags;
        logic       sticky;
        logic       st;
        logic       ack;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    or_event_aggregator #(.N(3), .STRETCH(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in        (in_v),
        .i_mask      (mask_v),
        .i_clr       (clr),
        .i_clr_sel   (clr_sel),
        .o_y         (y),
        .o_flags     (flags),
        .o_y_sticky  (y_sticky),
        .o_y_stretch (y_stretch),
        .o_clr_ack   (clr_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic add(input logic [2:0] i, input logic [2:0] m, input logic c, input logic [2:0] s,
                       input logic ey, input logic [2:0] ef, input logic est, input logic eack);
        vec_t v;
        v.in_v = i; v.mask_v = m; v.clr = c; v.sel = s;
        v.y = ey; v.flags = ef; v.st = est; v.ack = eack;
        vecs.push_back(v);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_y"},      0, y,         0);
        check({name, "_flags"},  0, flags,     0);
        check({name, "_sticky"}, 0, y_sticky,  0);
        check({name, "_stretch"},0, y_stretch, 0);
        check({name, "_ack"},    0, clr_ack,   0);
    endtask

    initial begin
        // Single pulse on channel 1: y one cycle, flag held, stretch exactly 4 cycles
        add(3'b010, 3'b000, 0, 3'b000, 1, 3'b010, 1, 0);
        add(3'b000, 3'b000, 0, 3'b000, 0, 3'b010, 1, 0);
        add(3'b000, 3'b000, 0, 3'b000, 0, 3'b010, 1, 0);
        add(3'b000, 3'b000, 0, 3'b000, 0, 3'b010, 1, 0);
        add(3'b000, 3'b000, 0, 3'b000, 0, 3'b010, 0, 0);
        add(3'b000, 3'b000, 0, 3'b000, 0, 3'b010, 0, 0);
        // Masked channel held: nothing new, existing flag untouched
        for (int k = 0; k < 5; k++) add(3'b100, 3'b100, 0, 3'b000, 0, 3'b010, 0, 0);
        // Partial clear of flags 011
        add(3'b001, 3'b000, 0, 3'b000, 1, 3'b011, 1, 0);
        add(3'b000, 3'b000, 1, 3'b001, 0, 3'b010, 1, 1);
        add(3'b000, 3'b000, 0, 3'b000, 0, 3'b010, 1, 0);
        // Set vs clear on channel 0 with line held
        add(3'b001, 3'b000, 1, 3'b001, 1, 3'b011, 1, 1);
        add(3'b001, 3'b000, 1, 3'b001, 1, EDGE ? 3'b010 : 3'b011, 1, 1);
        add(3'b001, 3'b000, 0, 3'b000, 1, EDGE ? 3'b010 : 3'b011, 1, 0);
        add(3'b000, 3'b000, 0, 3'b000, 0, EDGE ? 3'b010 : 3'b011, 1, 0);
        add(3'b000, 3'b000, 0, 3'b000, 0, EDGE ? 3'b010 : 3'b011, !EDGE, 0);
        add(3'b000, 3'b000, 0, 3'b000, 0, EDGE ? 3'b010 : 3'b011, !EDGE, 0);
        add(3'b000, 3'b000, 0, 3'b000, 0, EDGE ? 3'b010 : 3'b011, 0, 0);
        add(3'b000, 3'b000, 1, 3'b111, 0, 3'b000, 0, 1);
        // Retrigger: events two cycles apart give one continuous 6-cycle pulse
        add(3'b100, 3'b000, 0, 3'b000, 1, 3'b100, 1, 0);
        add(3'b000, 3'b000, 0, 3'b000, 0, 3'b100, 1, 0);
        add(3'b100, 3'b000, 0, 3'b000, 1, 3'b100, 1, 0);
        add(3'b000, 3'b000, 0, 3'b000, 0, 3'b100, 1, 0);
        add(3'b000, 3'b000, 0, 3'b000, 0, 3'b100, 1, 0);
        add(3'b000, 3'b000, 0, 3'b000, 0, 3'b100, 1, 0);
        add(3'b000, 3'b000, 0, 3'b000, 0, 3'b100, 0, 0);
        // Back-to-back clears with nothing selected still ack every cycle
        add(3'b000, 3'b000, 1, 3'b000, 0, 3'b100, 0, 1);
        add(3'b000, 3'b000, 1, 3'b000, 0, 3'b100, 0, 1);
        add(3'b000, 3'b000, 0, 3'b000, 0, 3'b100, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[n]) begin
            exp_t e;
            exp_t got;
            in_v = vecs[n].in_v; mask_v = vecs[n].mask_v;
            clr = vecs[n].clr;   clr_sel = vecs[n].sel;
            e.y = vecs[n].y; e.flags = vecs[n].flags; e.sticky = |vecs[n].flags;
            e.st = vecs[n].st; e.ack = vecs[n].ack;
            sb.push_back(e);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            check("y",       n, y,         got.y);
            check("flags",   n, flags,     got.flags);
            check("sticky",  n, y_sticky,  got.sticky);
            check("stretch", n, y_stretch, got.st);
            check("ack",     n, clr_ack,   got.ack);
            @(negedge clk);
        end

        // Reset mid-stretch with all flags set and a clear pending
        in_v = 3'b111; mask_v = '0; clr = 0; clr_sel = '0;
        @(negedge clk);
        in_v = 3'b000;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_flags",   0, flags,     3'b111);
        check("pre_rst_stretch", 0, y_stretch, 1);
        clr = 1; clr_sel = 3'b111;
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        clr = 0; clr_sel = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
